main_memory_lv2: RTL and testbench
==================================

// Module: main_memory_lv2
// PURPOSE
// - Main-memory responder at the far end of the lv2<->mem interface; serves line reads/writes issued by the lv2 cache.
// - Holds MEM_DEPTH lines; fixed, parameterised read/write latency; drives the shared tristate data_bus_lv2_mem only while responding.
// - Used as the memory model in system sims and as the memory-side endpoint in the 4-core MESI top.
// PARAMETERS
// - DATA_WID     `DATA_WID_LV2   line width on data_bus_lv2_mem
// - ADDR_WID     `ADDR_WID_LV2   address width
// - OFFSET_WID   `OFFSET_WID_LV2 byte-offset bits, ignored for indexing
// - MEM_IDX_WID  10              line index bits; MEM_DEPTH = 2**MEM_IDX_WID
// - RD_LAT       4               cycles from read sample to data_in_bus_lv2_mem rise, >=1
// - WR_LAT       4               cycles from write sample to mem_wr_done rise, >=1
// PORTS
// - clk                  in    1         clock, all logic on posedge
// - rst_n                in    1         synchronous active-low reset
// - addr_bus_lv2_mem     in    ADDR_WID  request address from lv2
// - data_bus_lv2_mem     inout DATA_WID  write data in; read data out, else 'z
// - mem_rd               in    1         read request, level, held until released by lv2
// - mem_wr               in    1         write request, level, held until mem_wr_done is seen
// - mem_wr_done          out   1         write committed; held while mem_wr stays high
// - data_in_bus_lv2_mem  out   1         read data valid on bus; held while mem_rd stays high
// - proto_err            out   1         sticky protocol error, present only with MEM_PROTO_CHECK_EN
// BEHAVIOUR
// - Reset, while rst_n is low at posedge: state=IDLE; mem_wr_done=0; data_in_bus_lv2_mem=0; bus released; all valid bits cleared; proto_err=0.
// - Reset mid-transaction aborts the transaction. A pending write is not committed.
// - Index: addr[OFFSET_WID+MEM_IDX_WID-1:OFFSET_WID]. Upper address bits alias.
// - Reading a line whose valid bit is 0 returns the captured address zero-extended to DATA_WID.
// - FSM states: IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_DONE. Latency counter is $clog2(max(RD_LAT,WR_LAT)+1) bits wide.
// - IDLE, mem_wr=1 sampled at edge k:
//   - capture addr and data; go to WR_WAIT.
//   - At edge k+WR_LAT: write the array, set the valid bit, mem_wr_done=1, go to WR_DONE.
// - IDLE, mem_rd=1 and mem_wr=0 at edge k:
//   - capture addr; go to RD_WAIT.
//   - At edge k+RD_LAT: read data registered, data_in_bus_lv2_mem=1, bus driven, go to RD_RESP.
// - mem_rd and mem_wr both high in IDLE: the write wins; the read is not served until the write handshake completes.
// - WR_DONE: stay while mem_wr=1. On the first edge sampling mem_wr=0: mem_wr_done=0, go to IDLE.
// - RD_RESP: stay while mem_rd=1. On the first edge sampling mem_rd=0: data_in_bus_lv2_mem=0, bus released on that same edge, go to IDLE.
// - Abort in RD_WAIT (mem_rd drops): go to IDLE; no response is given.
// - Abort in WR_WAIT (mem_wr drops): go to IDLE; the write is discarded.
// - Address and data changes after capture are ignored.
// - Bus drive enable is exactly data_in_bus_lv2_mem. There is never any drive outside RD_RESP.
// - After returning to IDLE, a new request is accepted no earlier than the next edge; no back-to-back in the same cycle.
// CONFIGURATION
// - MEM_PROTO_CHECK_EN defined:
//   - proto_err port exists.
//   - proto_err is set and held (until reset) on: rd&wr both high in IDLE; either abort case; mem_rd rising during a write or mem_wr rising during a read.
//   - Immediate assertions fire on the same conditions.
// - MEM_PROTO_CHECK_EN undefined: no proto_err port and no checks. All other behaviour is identical.
// STRUCTURE
// - mem_lv2_pkg holds: the state enum typedef mem_state_t; the default RD_LAT/WR_LAT constants; the function default_line(addr) that returns the unwritten-line pattern.
// - Sub-module mem_lv2_storage holds the line array plus the valid-bit vector:
//   - one synchronous write port; one registered read port; valid-bit clear on reset.
// - Top holds the FSM, latency counter, capture registers, tristate and checker.
// TESTING
// - Write then read back: write 0xA5..A5 to addr 0x40.
//   - mem_wr_done rises exactly 4 cycles after the sample.
//   - Read of 0x40 gives data_in_bus_lv2_mem 4 cycles later with bus = 0xA5..A5.
// - Unwritten read: read addr 0x1F80 after reset -> bus = 0x...1F80.
//   - Read again after a write+reset -> default pattern again.
// - Hold/release: keep mem_rd high 10 cycles in RD_RESP -> data held stable 10 cycles.
//   - Drop mem_rd -> flag and drive go low/'z the next edge.
// - Simultaneous rd+wr at addr 0x80: write completes first; mem_rd stays high.
//   - Read is served after mem_wr drops and returns the new data.
//   - With MEM_PROTO_CHECK_EN: proto_err=1.
// - Abort: drop mem_wr at cycle 2 of WR_WAIT -> no mem_wr_done; later read of that addr returns the old data.
// - Reset at cycle 2 of RD_WAIT -> no response; outputs 0; bus 'z.

Source files
------------

// File: rtl/mem_lv2_pkg.sv
// ============================================================================
// Module : mem_lv2_pkg
// Brief  : Shared widths, FSM state type and the unwritten-line pattern for main_memory_lv2.
// Rev    : 1.0
// ============================================================================
`default_nettype none

`ifndef DATA_WID_LV2
`define DATA_WID_LV2 128
`endif
`ifndef ADDR_WID_LV2
`define ADDR_WID_LV2 32
`endif
`ifndef OFFSET_WID_LV2
`define OFFSET_WID_LV2 4
`endif

package mem_lv2_pkg;

   localparam int LV2_DATA_WID   = `DATA_WID_LV2;
   localparam int LV2_ADDR_WID   = `ADDR_WID_LV2;
   localparam int LV2_OFFSET_WID = `OFFSET_WID_LV2;

   localparam int DEF_RD_LAT = 4;
   localparam int DEF_WR_LAT = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_WAIT = 3'd1,
      ST_RD_RESP = 3'd2,
      ST_WR_WAIT = 3'd3,
      ST_WR_DONE = 3'd4
   } mem_state_t;

   // A line never written reads back as its own request address.
   function automatic logic [LV2_DATA_WID-1:0] default_line(input logic [LV2_ADDR_WID-1:0] addr);
      return LV2_DATA_WID'(addr);
   endfunction

endpackage

`default_nettype wire

// File: rtl/main_memory_lv2_if.sv
// ============================================================================
// Module : main_memory_lv2_if
// Brief  : lv2 <-> main-memory request bus with shared tristate data lines.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface main_memory_lv2_if
   import mem_lv2_pkg::*;
#(
   parameter int DATA_WID = LV2_DATA_WID,
   parameter int ADDR_WID = LV2_ADDR_WID
) ();

   logic [ADDR_WID-1:0] addr_bus_lv2_mem;
   wire  [DATA_WID-1:0] data_bus_lv2_mem;
   logic                mem_rd;
   logic                mem_wr;
   logic                mem_wr_done;
   logic                data_in_bus_lv2_mem;

   modport master (
      output addr_bus_lv2_mem,
      output mem_rd,
      output mem_wr,
      input  mem_wr_done,
      input  data_in_bus_lv2_mem,
      inout  data_bus_lv2_mem
   );

   modport slave (
      input  addr_bus_lv2_mem,
      input  mem_rd,
      input  mem_wr,
      output mem_wr_done,
      output data_in_bus_lv2_mem,
      inout  data_bus_lv2_mem
   );

endinterface

`default_nettype wire

// File: rtl/mem_lv2_storage.sv
// ============================================================================
// Module : mem_lv2_storage
// Brief  : Line array with one synchronous write port, one registered read port
//          and a per-line valid vector cleared on reset.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_lv2_storage #(
   parameter int DATA_WID = 128,
   parameter int IDX_WID  = 10
) (
   input  wire logic                clk,
   input  wire logic                rst_n,
   input  wire logic                wr_en,
   input  wire logic [IDX_WID-1:0]  wr_idx,
   input  wire logic [DATA_WID-1:0] wr_data,
   input  wire logic                rd_en,
   input  wire logic [IDX_WID-1:0]  rd_idx,
   output logic      [DATA_WID-1:0] rd_data,
   output logic                     rd_valid
);

   localparam int DEPTH = 2 ** IDX_WID;

   logic [DATA_WID-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0]    valid_q, valid_d;
   logic [DATA_WID-1:0] rd_data_q, rd_data_d;
   logic                rd_valid_q, rd_valid_d;

   always_comb begin
      valid_d    = valid_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = rd_valid_q;
      if (wr_en) begin
         valid_d[wr_idx] = 1'b1;
      end
      if (rd_en) begin
         rd_data_d  = mem_q[rd_idx];
         rd_valid_d = valid_q[rd_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   // Array itself is left unreset so it maps onto block RAM; valid bits mask stale contents.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_idx] <= wr_data;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;

endmodule

`default_nettype wire

// File: rtl/main_memory_lv2.sv
// ============================================================================
// Module : main_memory_lv2
// Brief  : Fixed-latency main-memory responder for the lv2 cache line bus.
//          Optional protocol checker and proto_err port via MEM_PROTO_CHECK_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module main_memory_lv2
   import mem_lv2_pkg::*;
#(
   parameter int DATA_WID    = LV2_DATA_WID,
   parameter int ADDR_WID    = LV2_ADDR_WID,
   parameter int OFFSET_WID  = LV2_OFFSET_WID,
   parameter int MEM_IDX_WID = 10,
   parameter int RD_LAT      = DEF_RD_LAT,
   parameter int WR_LAT      = DEF_WR_LAT
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   main_memory_lv2_if.slave bus
`ifdef MEM_PROTO_CHECK_EN
   ,
   output logic             proto_err
`endif
);

   localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
   localparam int CNT_WID = $clog2(MAX_LAT + 1);

   localparam logic [2:0] IDLE    = ST_IDLE;
   localparam logic [2:0] RD_WAIT = ST_RD_WAIT;
   localparam logic [2:0] RD_RESP = ST_RD_RESP;
   localparam logic [2:0] WR_WAIT = ST_WR_WAIT;
   localparam logic [2:0] WR_DONE = ST_WR_DONE;

   logic [2:0]          state_q, state_d;
   logic [CNT_WID-1:0]  cnt_q, cnt_d;
   logic [ADDR_WID-1:0] cap_addr_q, cap_addr_d;
   logic [DATA_WID-1:0] cap_data_q, cap_data_d;
   logic                wr_done_q, wr_done_d;
   logic                rd_vld_q, rd_vld_d;

   logic                   mem_rd, mem_wr, cnt_zero;
   logic                   st_wr, st_rd;
   logic [MEM_IDX_WID-1:0] line_idx;
   logic [DATA_WID-1:0]    st_rd_data, resp_data;
   logic                   st_rd_valid;

   assign mem_rd   = bus.mem_rd;
   assign mem_wr   = bus.mem_wr;
   assign cnt_zero = (cnt_q == '0);
   assign line_idx = cap_addr_q[OFFSET_WID+MEM_IDX_WID-1:OFFSET_WID];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cap_addr_d = cap_addr_q;
      cap_data_d = cap_data_q;
      wr_done_d  = wr_done_q;
      rd_vld_d   = rd_vld_q;
      st_wr      = 1'b0;
      st_rd      = 1'b0;
      case (state_q)
         IDLE: begin
            // Write has priority when both requests arrive together.
            if (mem_wr) begin
               cap_addr_d = bus.addr_bus_lv2_mem;
               cap_data_d = bus.data_bus_lv2_mem;
               cnt_d      = CNT_WID'(WR_LAT - 1);
               state_d    = WR_WAIT;
            end else if (mem_rd) begin
               cap_addr_d = bus.addr_bus_lv2_mem;
               cnt_d      = CNT_WID'(RD_LAT - 1);
               state_d    = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (!mem_rd) begin
               state_d = IDLE;
            end else if (cnt_zero) begin
               st_rd    = 1'b1;
               rd_vld_d = 1'b1;
               state_d  = RD_RESP;
            end else begin
               cnt_d = cnt_q - CNT_WID'(1);
            end
         end
         RD_RESP: begin
            if (!mem_rd) begin
               rd_vld_d = 1'b0;
               state_d  = IDLE;
            end
         end
         WR_WAIT: begin
            if (!mem_wr) begin
               state_d = IDLE;
            end else if (cnt_zero) begin
               st_wr     = 1'b1;
               wr_done_d = 1'b1;
               state_d   = WR_DONE;
            end else begin
               cnt_d = cnt_q - CNT_WID'(1);
            end
         end
         WR_DONE: begin
            if (!mem_wr) begin
               wr_done_d = 1'b0;
               state_d   = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         cap_addr_q <= '0;
         cap_data_q <= '0;
         wr_done_q  <= 1'b0;
         rd_vld_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cap_addr_q <= cap_addr_d;
         cap_data_q <= cap_data_d;
         wr_done_q  <= wr_done_d;
         rd_vld_q   <= rd_vld_d;
      end
   end

   mem_lv2_storage #(
      .DATA_WID (DATA_WID),
      .IDX_WID  (MEM_IDX_WID)
   ) u_storage (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (st_wr & rst_n),
      .wr_idx   (line_idx),
      .wr_data  (cap_data_q),
      .rd_en    (st_rd & rst_n),
      .rd_idx   (line_idx),
      .rd_data  (st_rd_data),
      .rd_valid (st_rd_valid)
   );

   assign resp_data = st_rd_valid ? st_rd_data
                                  : DATA_WID'(default_line(LV2_ADDR_WID'(cap_addr_q)));

   assign bus.mem_wr_done         = wr_done_q;
   assign bus.data_in_bus_lv2_mem = rd_vld_q;
   assign bus.data_bus_lv2_mem    = rd_vld_q ? resp_data : {DATA_WID{1'bz}};

`ifdef MEM_PROTO_CHECK_EN
   logic proto_err_q, proto_err_d;
   logic rd_prev_q, wr_prev_q;
   logic viol_rdwr, viol_abort, viol_cross;

   always_comb begin
      viol_rdwr   = (state_q == IDLE) && mem_rd && mem_wr;
      viol_abort  = ((state_q == RD_WAIT) && !mem_rd) || ((state_q == WR_WAIT) && !mem_wr);
      viol_cross  = (((state_q == WR_WAIT) || (state_q == WR_DONE)) && mem_rd && !rd_prev_q) ||
                    (((state_q == RD_WAIT) || (state_q == RD_RESP)) && mem_wr && !wr_prev_q);
      proto_err_d = proto_err_q | viol_rdwr | viol_abort | viol_cross;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         proto_err_q <= 1'b0;
         rd_prev_q   <= 1'b0;
         wr_prev_q   <= 1'b0;
      end else begin
         proto_err_q <= proto_err_d;
         rd_prev_q   <= mem_rd;
         wr_prev_q   <= mem_wr;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         a_rdwr:  assert (!viol_rdwr)  else $error("main_memory_lv2: rd and wr together in IDLE");
         a_abort: assert (!viol_abort) else $error("main_memory_lv2: request dropped before response");
         a_cross: assert (!viol_cross) else $error("main_memory_lv2: request raised during other transfer");
      end
   end

   assign proto_err = proto_err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_main_memory_lv2.sv
// ============================================================================
// Module : tb_main_memory_lv2
// Brief  : Directed vector bench for main_memory_lv2 (default 128b line, 4-cycle latency).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_main_memory_lv2;
   import mem_lv2_pkg::*;

   localparam int DW = LV2_DATA_WID;
   localparam int AW = LV2_ADDR_WID;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   main_memory_lv2_if #(.DATA_WID(DW), .ADDR_WID(AW)) bus_if ();

   logic          drv_en = 1'b0;
   logic [DW-1:0] drv_data = '0;
   assign bus_if.data_bus_lv2_mem = drv_en ? drv_data : {DW{1'bz}};

`ifdef MEM_PROTO_CHECK_EN
   wire proto_err;
`endif

   main_memory_lv2 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
`ifdef MEM_PROTO_CHECK_EN
      ,
      .proto_err (proto_err)
`endif
   );

   typedef struct {
      bit            is_wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int            hold;
   } vec_t;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic chk_i(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   // Bus released: a probe driven by the bench must read back unchanged.
   task automatic chk_released(input string nm, input logic [DW-1:0] probe);
      drv_data = probe;
      drv_en   = 1'b1;
      #1;
      chk(nm, bus_if.data_bus_lv2_mem, probe);
      drv_en   = 1'b0;
   endtask

   task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input string tag);
      int lat;
      @(negedge clk);
      bus_if.addr_bus_lv2_mem = addr;
      drv_data = data;
      drv_en   = 1'b1;
      bus_if.mem_wr = 1'b1;
      lat = 99;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (bus_if.mem_wr_done === 1'b1) begin
            lat = c - 1;
            break;
         end
      end
      chk_i({tag, "_wr_lat"}, lat, 4);
      bus_if.mem_wr = 1'b0;
      drv_en = 1'b0;
      @(negedge clk);
      chk({tag, "_wr_done_drop"}, DW'(bus_if.mem_wr_done), '0);
   endtask

   task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] exp,
                          input int hold, input string tag);
      int lat;
      int bad;
      @(negedge clk);
      bus_if.addr_bus_lv2_mem = addr;
      bus_if.mem_rd = 1'b1;
      lat = 99;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (bus_if.data_in_bus_lv2_mem === 1'b1) begin
            lat = c - 1;
            break;
         end
      end
      chk_i({tag, "_rd_lat"}, lat, 4);
      chk({tag, "_rd_data"}, bus_if.data_bus_lv2_mem, exp);
      if (hold > 0) begin
         bad = 0;
         for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (bus_if.data_in_bus_lv2_mem !== 1'b1 || bus_if.data_bus_lv2_mem !== exp) bad++;
         end
         chk_i({tag, "_hold_stable"}, bad, 0);
      end
      bus_if.mem_rd = 1'b0;
      @(negedge clk);
      chk({tag, "_rd_flag_drop"}, DW'(bus_if.data_in_bus_lv2_mem), '0);
      chk_released({tag, "_rd_release"}, ~exp);
   endtask

   vec_t vecs[10];

   initial begin
      int seen;
      logic [DW-1:0] pat_a5, pat_12, pat_3c, pat_be, pat_ff;

      bus_if.addr_bus_lv2_mem = '0;
      bus_if.mem_rd = 1'b0;
      bus_if.mem_wr = 1'b0;

      pat_a5 = {16{8'hA5}};
      pat_12 = {4{32'h1234_5678}};
      pat_3c = {16{8'h3C}};
      pat_be = {8{16'hBEEF}};
      pat_ff = {16{8'hFF}};

      vecs[0] = '{1'b0, 32'h0000_1F80, DW'(32'h1F80), 0};
      vecs[1] = '{1'b1, 32'h0000_0040, pat_a5,        0};
      vecs[2] = '{1'b0, 32'h0000_0040, pat_a5,        10};
      vecs[3] = '{1'b0, 32'h0000_004F, pat_a5,        0};
      vecs[4] = '{1'b0, 32'h0000_4040, pat_a5,        0};
      vecs[5] = '{1'b1, 32'h0000_0080, pat_12,        0};
      vecs[6] = '{1'b0, 32'h0000_0080, pat_12,        0};
      vecs[7] = '{1'b1, 32'h0000_00C0, pat_3c,        0};
      vecs[8] = '{1'b0, 32'h0000_00C0, pat_3c,        0};
      vecs[9] = '{1'b0, 32'h0000_0050, DW'(32'h50),   0};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_wr_done", DW'(bus_if.mem_wr_done), '0);
      chk("rst_rd_flag", DW'(bus_if.data_in_bus_lv2_mem), '0);
      chk_released("rst_bus_release", '0);
`ifdef MEM_PROTO_CHECK_EN
      chk("rst_proto_err", DW'(proto_err), '0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         if (vecs[i].is_wr)
            do_write(vecs[i].addr, vecs[i].data, $sformatf("v%0d", i));
         else
            do_read(vecs[i].addr, vecs[i].data, vecs[i].hold, $sformatf("v%0d", i));
      end

      // Simultaneous rd+wr: write completes first, then read returns new data
      begin
         int lat;
         int early;
         @(negedge clk);
         bus_if.addr_bus_lv2_mem = 32'h80;
         drv_data = pat_be;
         drv_en   = 1'b1;
         bus_if.mem_wr = 1'b1;
         bus_if.mem_rd = 1'b1;
         lat = 99;
         early = 0;
         for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus_if.data_in_bus_lv2_mem === 1'b1) early++;
            if (bus_if.mem_wr_done === 1'b1) begin
               lat = c - 1;
               break;
            end
         end
         chk_i("sim_wr_lat", lat, 4);
         chk_i("sim_no_early_rd", early, 0);
`ifdef MEM_PROTO_CHECK_EN
         chk("sim_proto_err", DW'(proto_err), DW'(1'b1));
`endif
         bus_if.mem_wr = 1'b0;
         drv_en = 1'b0;
         @(negedge clk);
         chk("sim_wr_done_drop", DW'(bus_if.mem_wr_done), '0);
         lat = 99;
         for (int c = 2; c <= 20; c++) begin
            @(negedge clk);
            if (bus_if.data_in_bus_lv2_mem === 1'b1) begin
               lat = c - 1;
               break;
            end
         end
         chk_i("sim_rd_lat", lat, 5);
         chk("sim_rd_data", bus_if.data_bus_lv2_mem, pat_be);
         bus_if.mem_rd = 1'b0;
         @(negedge clk);
         chk("sim_rd_flag_drop", DW'(bus_if.data_in_bus_lv2_mem), '0);
      end

      // Write abort in WR_WAIT: no completion, old data kept
      @(negedge clk);
      bus_if.addr_bus_lv2_mem = 32'hC0;
      drv_data = pat_ff;
      drv_en   = 1'b1;
      bus_if.mem_wr = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus_if.mem_wr = 1'b0;
      drv_en = 1'b0;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus_if.mem_wr_done !== 1'b0) seen++;
      end
      chk_i("abort_no_wr_done", seen, 0);
      do_read(32'hC0, pat_3c, 0, "abort");

      // Reset during RD_WAIT: no response, outputs low, bus released
      @(negedge clk);
      bus_if.addr_bus_lv2_mem = 32'h40;
      bus_if.mem_rd = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mrst_rd_flag", DW'(bus_if.data_in_bus_lv2_mem), '0);
      chk("mrst_wr_done", DW'(bus_if.mem_wr_done), '0);
      chk_released("mrst_bus_release", '0);
      bus_if.mem_rd = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus_if.data_in_bus_lv2_mem !== 1'b0) seen++;
      end
      chk_i("mrst_no_response", seen, 0);

      // Valid bits cleared by reset: previously written lines read as default pattern
      do_read(32'h40, DW'(32'h40), 0, "post_rst_40");
      do_read(32'h1F80, DW'(32'h1F80), 0, "post_rst_1f80");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
